// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU bus constants and sprite DMA state encoding
//
// Purpose: constants shared by the PPU register-port blocks.
//   TRIG_ADDR : CPU write address that launches a sprite DMA
//   OAM_ADDR  : PPU OAMDATA register every fetched byte lands in
//   LEN       : bytes per sprite DMA (fixed at one page)
//   IDX_LAST  : index of the final byte in a page
//   dma_state_t : 3-bit sprite DMA FSM encoding
package ppu_pkg;

   localparam logic [15:0] TRIG_ADDR = 16'h4014;
   localparam logic [15:0] OAM_ADDR  = 16'h2004;
   localparam int          LEN       = 256;
   localparam logic [7:0]  IDX_LAST  = 8'(LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA bus initiator copying one CPU page into PPU OAMDATA
//
// Purpose: snoops CPU writes to TRIG_ADDR, halts the CPU and copies page
//   {data,8'h00}..{data,8'hFF} into OAM_ADDR, one read/write pair per byte.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   ce                  : CPU-cycle enable; state only advances when high
//   cpu_addr/out/we     : snooped CPU bus
//   bus_in              : read data, valid in the ce-cycle after dma_rd
//   cpu_en              : 0 while the CPU is halted for DMA
//   dma_busy            : 1 while this block owns the bus
//   dma_addr/out/rd/we  : bus drive while busy
//   dma_done            : one-ce-cycle pulse after the last write
module oam_dma
   import ppu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   input  logic [7:0]  bus_in,
   output logic        cpu_en,
   output logic        dma_busy,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_out,
   output logic        dma_rd,
   output logic        dma_we,
   output logic        dma_done
);

   dma_state_t state, state_nxt;
   logic [7:0] page, page_nxt;
   logic [7:0] idx, idx_nxt;
   logic       parity;
   logic       trig;

   assign trig = cpu_we && (cpu_addr == TRIG_ADDR);

   // Parity tracks CPU get/put cycles and runs whether or not a DMA is active,
   // so the HALT decision sees the true bus phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= ST_IDLE;
         page   <= 8'h00;
         idx    <= 8'h00;
         parity <= 1'b0;
      end else if (ce) begin
         state  <= state_nxt;
         page   <= page_nxt;
         idx    <= idx_nxt;
         parity <= ~parity;
      end
   end

   always_comb begin
      state_nxt = state;
      page_nxt  = page;
      idx_nxt   = idx;
      cpu_en    = 1'b1;
      dma_busy  = 1'b0;
      dma_addr  = 16'h0000;
      dma_out   = 8'h00;
      dma_rd    = 1'b0;
      dma_we    = 1'b0;
      dma_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trig) begin
               page_nxt  = cpu_out;
               idx_nxt   = 8'h00;
               state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            cpu_en    = 1'b0;
            dma_busy  = 1'b1;
            // An odd phase needs one extra dummy cycle so reads land on get cycles.
            state_nxt = parity ? ST_ALIGN : ST_READ;
         end
         ST_ALIGN: begin
            cpu_en    = 1'b0;
            dma_busy  = 1'b1;
            state_nxt = ST_READ;
         end
         ST_READ: begin
            cpu_en    = 1'b0;
            dma_busy  = 1'b1;
            dma_addr  = {page, idx};
            dma_rd    = 1'b1;
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            cpu_en   = 1'b0;
            dma_busy = 1'b1;
            dma_addr = OAM_ADDR;
            dma_we   = 1'b1;
            dma_out  = bus_in;
            // idx never carries into page: the source stays inside one page.
            if (idx == IDX_LAST) begin
               state_nxt = ST_DONE;
            end else begin
               idx_nxt   = idx + 8'd1;
               state_nxt = ST_READ;
            end
         end
         ST_DONE: begin
            dma_done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard testbench for oam_dma
module tb_oam_dma;

   logic        clock = 1'b0;
   logic        reset;
   logic        ce;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_out;
   logic        cpu_we;
   logic [7:0]  bus_in = 8'h00;
   logic        cpu_en;
   logic        dma_busy;
   logic [15:0] dma_addr;
   logic [7:0]  dma_out;
   logic        dma_rd;
   logic        dma_we;
   logic        dma_done;

   oam_dma dut (
      .clock    (clock),
      .reset    (reset),
      .ce       (ce),
      .cpu_addr (cpu_addr),
      .cpu_out  (cpu_out),
      .cpu_we   (cpu_we),
      .bus_in   (bus_in),
      .cpu_en   (cpu_en),
      .dma_busy (dma_busy),
      .dma_addr (dma_addr),
      .dma_out  (dma_out),
      .dma_rd   (dma_rd),
      .dma_we   (dma_we),
      .dma_done (dma_done)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // memory model
   int mem_mode = 0;
   function automatic logic [7:0] mem_val(input logic [15:0] a);
      if (mem_mode == 1) return a[7:0];
      return a[7:0] ^ (a[15:8] + 8'h3C);
   endfunction

   always @(posedge clock) begin
      if (ce && dma_rd) bus_in <= mem_val(dma_addr);
   end

   // scoreboard and monitor
   logic [15:0] rq[$];
   logic [7:0]  wq[$];
   logic [15:0] ea;
   logic [15:0] last_rd_addr;
   int stall, rd_cnt, wr_cnt, first_rd_at, done_cnt = 0;
   logic hold_valid = 1'b0;
   logic h_rd, h_we;
   logic [15:0] h_addr;

   always @(negedge clock) begin
      if (reset) begin
         hold_valid = 1'b0;
      end else if (ce) begin
         if (hold_valid) begin
            check("hold_rd", 32'(dma_rd), 32'(h_rd));
            check("hold_we", 32'(dma_we), 32'(h_we));
            check("hold_addr", 32'(dma_addr), 32'(h_addr));
            hold_valid = 1'b0;
         end
         if (dma_rd && dma_we) check("rd_we_excl", 32'd1, 32'd0);
         if (!cpu_en) stall++;
         if (dma_rd) begin
            rd_cnt++;
            if (rd_cnt == 1) first_rd_at = stall;
            if (rq.size() == 0) begin
               check("rd_extra", 32'(dma_addr), 32'hFFFF_FFFF);
            end else begin
               ea = rq.pop_front();
               check("rd_addr", 32'(dma_addr), 32'(ea));
               wq.push_back(mem_val(ea));
            end
            last_rd_addr = dma_addr;
         end
         if (dma_we) begin
            wr_cnt++;
            check("wr_addr", 32'(dma_addr), 32'h2004);
            if (wq.size() == 0) check("wr_extra", 32'(dma_out), 32'hFFFF_FFFF);
            else check("wr_data", 32'(dma_out), 32'(wq.pop_front()));
         end else begin
            check("out_idle_zero", 32'(dma_out), 32'd0);
         end
         if (dma_done) done_cnt++;
      end else begin
         h_rd = dma_rd;
         h_we = dma_we;
         h_addr = dma_addr;
         hold_valid = 1'b1;
      end
   end

   // stimulus
   logic toggle = 1'b0;
   logic tb_par = 1'b0;
   int done0;

   task automatic step();
      @(posedge clock);
      if (reset) tb_par = 1'b0;
      else if (ce) tb_par = ~tb_par;
      #1;
      ce = toggle ? ~ce : 1'b1;
   endtask

   task automatic start_xfer(input logic [7:0] page, input logic hp);
      int n;
      n = 0;
      while (!(ce && (tb_par == ~hp)) && n < 10) begin
         step();
         n++;
      end
      stall = 0; rd_cnt = 0; wr_cnt = 0; first_rd_at = -1;
      done0 = done_cnt;
      for (int i = 0; i < 256; i++) rq.push_back({page, 8'(i)});
      cpu_addr = 16'h4014;
      cpu_out  = page;
      cpu_we   = 1'b1;
      step();
      cpu_we   = 1'b0;
      cpu_addr = 16'h0000;
      cpu_out  = 8'h00;
   endtask

   task automatic finish_xfer(input logic hp, input logic [15:0] last_addr);
      int n;
      n = 0;
      while (done_cnt == done0 && n < 3000) begin
         step();
         n++;
      end
      if (done_cnt == done0) check("done_timeout", 32'd0, 32'd1);
      repeat (6) step();
      check("stall_len", 32'(stall), hp ? 32'd514 : 32'd513);
      check("first_rd", 32'(first_rd_at), hp ? 32'd3 : 32'd2);
      check("rd_count", 32'(rd_cnt), 32'd256);
      check("wr_count", 32'(wr_cnt), 32'd256);
      check("done_count", 32'(done_cnt - done0), 32'd1);
      check("rq_left", 32'(rq.size()), 32'd0);
      check("wq_left", 32'(wq.size()), 32'd0);
      check("last_rd", 32'(last_rd_addr), 32'(last_addr));
      check("post_cpu_en", 32'(cpu_en), 32'd1);
      check("post_busy", 32'(dma_busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1; cpu_addr = 16'h0000; cpu_out = 8'h00; cpu_we = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      check("rst_cpu_en", 32'(cpu_en), 32'd1);
      check("rst_busy", 32'(dma_busy), 32'd0);
      check("rst_rd", 32'(dma_rd), 32'd0);
      check("rst_we", 32'(dma_we), 32'd0);
      check("rst_done", 32'(dma_done), 32'd0);
      check("rst_addr", 32'(dma_addr), 32'd0);
      check("rst_out", 32'(dma_out), 32'd0);
      repeat (3) step();

      // 1: even phase, page 02
      start_xfer(8'h02, 1'b0);
      finish_xfer(1'b0, 16'h02FF);

      // 2: odd phase adds ALIGN
      start_xfer(8'h02, 1'b1);
      finish_xfer(1'b1, 16'h02FF);

      // 3: page FF, no carry into page
      mem_mode = 1;
      start_xfer(8'hFF, 1'b0);
      finish_xfer(1'b0, 16'hFFFF);
      mem_mode = 0;

      // 4: ce toggling every clock
      toggle = 1'b1;
      start_xfer(8'h5A, 1'b0);
      finish_xfer(1'b0, 16'h5AFF);
      toggle = 1'b0;
      step();

      // 5: reset mid-transfer, then a clean transfer
      start_xfer(8'h10, 1'b1);
      for (int n = 0; n < 2000 && wr_cnt < 100; n++) step();
      check("reached_byte100", 32'(wr_cnt), 32'd100);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_cpu_en", 32'(cpu_en), 32'd1);
      check("midrst_busy", 32'(dma_busy), 32'd0);
      check("midrst_we", 32'(dma_we), 32'd0);
      check("midrst_done", 32'(dma_done), 32'd0);
      repeat (5) step();
      check("midrst_no_done", 32'(done_cnt - done0), 32'd0);
      check("midrst_idle_en", 32'(cpu_en), 32'd1);
      rq.delete();
      wq.delete();
      start_xfer(8'h21, 1'b0);
      finish_xfer(1'b0, 16'h21FF);

      // 6: near-miss writes and a read of the trigger address
      stall = 0;
      done0 = done_cnt;
      for (int k = 0; k < 3; k++) begin
         cpu_addr = (k == 0) ? 16'h4013 : (k == 1) ? 16'h4015 : 16'h4014;
         cpu_out  = 8'h03;
         cpu_we   = (k != 2);
         step();
         cpu_we   = 1'b0;
         step();
         check("nt_busy", 32'(dma_busy), 32'd0);
         check("nt_cpu_en", 32'(cpu_en), 32'd1);
      end
      cpu_addr = 16'h0000;
      repeat (5) step();
      check("nt_stall", 32'(stall), 32'd0);
      check("nt_done", 32'(done_cnt - done0), 32'd0);
      check("nt_rd", 32'(dma_rd), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
